// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and state encoding for the 7-segment
//               display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Width of the digit select driven into the 4-to-1 display mux.
  localparam int SEL_W = 2;

  // Largest number of digits the fixed-width select can address.
  localparam int MAX_DIGITS = 4;

  // Active-low anode enables with every digit dark.
  localparam logic [MAX_DIGITS-1:0] ANODE_ALL_OFF = {MAX_DIGITS{1'b1}};

  // Scan FSM: a dark settling gap, then the lit portion of the slot.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_next_digit.sv
`default_nettype none
// ============================================================================
// Module      : seg7_next_digit
// Description : Combinational masked rotate-priority search. Starting one
//               position after the current select and moving upward modulo
//               NUM_DIGITS, returns the first digit whose mask bit is set,
//               and flags when that choice wraps back to or below the
//               current select. With an empty mask the select is held and
//               no wrap is reported.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_next_digit
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [NUM_DIGITS-1:0] i_digit_mask,
  output logic [SEL_W-1:0]      o_next_sel,
  output logic                  o_wrap
);

  // Mask zero-extended to the full select range so any 2-bit index is legal.
  logic [MAX_DIGITS-1:0] w_mask_pad;
  logic [SEL_W-1:0]      w_cand;
  logic                  w_found;

  assign w_mask_pad = MAX_DIGITS'(i_digit_mask);

  // Walk sel+1, sel+2, ... (mod NUM_DIGITS); the first enabled digit wins.
  // The final candidate (k == NUM_DIGITS) is the current digit itself, which
  // covers the single-enabled-digit case.
  always_comb begin
    o_next_sel = i_sel;
    o_wrap     = 1'b0;
    w_found    = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      w_cand = SEL_W'((int'(i_sel) + k) % NUM_DIGITS);
      if (!w_found && w_mask_pad[w_cand]) begin
        w_found    = 1'b1;
        o_next_sel = w_cand;
        o_wrap     = (w_cand <= i_sel);
      end
    end
  end

endmodule : seg7_next_digit
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode
//               7-segment display. Each digit slot is REFRESH_DIV cycles:
//               BLANK_CYCLES with every anode off so the mux settles, then
//               the selected digit lit. Masked-off digits are skipped, a
//               pulse marks each wrap of the rotation, and dropping enable
//               forces the display dark while holding the select.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [NUM_DIGITS-1:0] i_digit_mask,
  output logic [SEL_W-1:0]      o_select,
  output logic [NUM_DIGITS-1:0] o_anode_n,
  output logic                  o_blank,
  output logic                  o_frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Terminal counts of the two phases of a slot.
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] c_all_off = ANODE_ALL_OFF[NUM_DIGITS-1:0];

  // Registered state and outputs.
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_DIGITS-1:0] r_anode_n;
  logic                  r_blank;
  logic                  r_frame_done;

  // Next-state values produced by the combinational half of the FSM.
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [SEL_W-1:0]      w_sel_nxt;
  logic [NUM_DIGITS-1:0] w_anode_n_nxt;
  logic                  w_blank_nxt;
  logic                  w_frame_done_nxt;

  // Lit pattern for the current select under the current mask.
  logic [MAX_DIGITS-1:0] w_mask_pad;
  logic [MAX_DIGITS-1:0] w_onehot;
  logic [MAX_DIGITS-1:0] w_lit;
  logic [NUM_DIGITS-1:0] w_lit_anode_n;
  logic                  w_cur_on;
  logic                  w_mask_any;

  // Result of the rotate-priority search.
  logic [SEL_W-1:0]      w_next_sel;
  logic                  w_wrap;

  assign w_mask_pad    = MAX_DIGITS'(i_digit_mask);
  assign w_onehot      = MAX_DIGITS'(1) << r_sel;
  assign w_lit         = w_onehot & w_mask_pad;
  assign w_lit_anode_n = ~w_lit[NUM_DIGITS-1:0];
  assign w_cur_on      = |w_lit;
  assign w_mask_any    = |i_digit_mask;

  seg7_next_digit #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_next_digit (
    .i_sel        (r_sel),
    .i_digit_mask (i_digit_mask),
    .o_next_sel   (w_next_sel),
    .o_wrap       (w_wrap)
  );

  // Next-state and next-output logic; outputs default to dark every cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sel_nxt        = r_sel;
    w_anode_n_nxt    = c_all_off;
    w_blank_nxt      = 1'b1;
    w_frame_done_nxt = 1'b0;

    if (!i_enable) begin
      // Park in a fresh blanking gap; the select is kept so scanning
      // resumes on the same digit.
      w_state_nxt = BLANK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nxt   = SHOW;
            w_cnt_nxt     = '0;
            w_anode_n_nxt = w_lit_anode_n;
            w_blank_nxt   = ~w_cur_on;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        SHOW: begin
          if (r_cnt == c_show_last) begin
            // Slot ends: advance using the mask seen on this last cycle.
            // An empty mask keeps the select and produces no frame pulse.
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            if (w_mask_any) begin
              w_sel_nxt        = w_next_sel;
              w_frame_done_nxt = w_wrap;
            end
          end else begin
            // Anode tracks mask changes within the slot on the next edge.
            w_cnt_nxt     = r_cnt + CNT_W'(1);
            w_anode_n_nxt = w_lit_anode_n;
            w_blank_nxt   = ~w_cur_on;
          end
        end

        default: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, slot counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_anode_n    <= c_all_off;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_anode_n    <= w_anode_n_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign o_select     = r_sel;
  assign o_anode_n    = r_anode_n;
  assign o_blank      = r_blank;
  assign o_frame_done = r_frame_done;

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Directed self-checking bench for seg7_scan_ctrl with
//               NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2. Each observed
//               value is the packed tuple {anode_n, select, blank, frame_done}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] mask;
  logic [1:0] sel;
  logic [3:0] anode_n;
  logic       blank;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .i_digit_mask (mask),
    .o_select     (sel),
    .o_anode_n    (anode_n),
    .o_blank      (blank),
    .o_frame_done (frame_done)
  );

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset; on return the DUT is at its post-reset state (t = 0).
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp_v;
    enable = 1'b1;
    mask   = 4'b1111;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs   = {anode_n, sel, blank, frame_done};
      exp_v = {4'b1111, 2'd0, 1'b1, 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    reset = 1'b0;
    tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1111, 2'd0, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release_dark got=%b exp=%b", obs, exp_v);
    end
    tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1110, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_first_lit got=%b exp=%b", obs, exp_v);
    end
  endtask

  // Digits 0 and 1: 2 dark + 6 lit per slot, wrap pulse on return to 0.
  task automatic test_two_digits();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic [3:0] ea;
    int ph;
    mask = 4'b0011;
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      tick();
      ph = t % 8;
      es = 2'((t / 8) % 2);
      ea = (ph >= 2) ? ~(4'b0001 << es) : 4'b1111;
      exp_v = {ea, es, (ph < 2), (ph == 0) && (es == 2'd0)};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL two_digits t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  // Digits 0 and 2 alternate; 1 and 3 are skipped.
  task automatic test_alternate();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic [3:0] ea;
    int ph;
    mask = 4'b0101;
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      tick();
      ph = t % 8;
      es = 2'(((t / 8) % 2) * 2);
      ea = (ph >= 2) ? ~(4'b0001 << es) : 4'b1111;
      exp_v = {ea, es, (ph < 2), (ph == 0) && (es == 2'd0)};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL alternate t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  // Empty mask keeps everything dark and quiet; then a lone digit 3.
  task automatic test_mask_zero();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic       lit;
    int ph;
    mask = 4'b0000;
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp_v = {4'b1111, 2'd0, 1'b1, 1'b0};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mask_zero t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
    mask = 4'b1000;
    for (int t = 41; t <= 80; t++) begin
      tick();
      ph  = t % 8;
      es  = (t >= 48) ? 2'd3 : 2'd0;
      lit = (t >= 48) && (ph >= 2);
      exp_v = {lit ? 4'b0111 : 4'b1111, es, !lit, (ph == 0) && (t >= 56)};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_digit3 t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  // Reset pulse during the lit part of digit 2.
  task automatic test_reset_mid_show();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic [3:0] ea;
    int ph;
    mask = 4'b1111;
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      tick();
      ph = t % 8;
      es = 2'((t / 8) % 4);
      ea = (ph >= 2) ? ~(4'b0001 << es) : 4'b1111;
      exp_v = {ea, es, (ph < 2), 1'b0};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset_scan t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1111, 2'd0, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_values got=%b exp=%b", obs, exp_v);
    end
    tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1111, 2'd0, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_blank2 got=%b exp=%b", obs, exp_v);
    end
    tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1110, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_relit got=%b exp=%b", obs, exp_v);
    end
  endtask

  // Dropping mask bit 0 while digit 0 is lit darkens it next edge, and the
  // advance then skips to digit 1.
  task automatic test_mask_mid_slot();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic       lit;
    mask = 4'b1111;
    do_reset();
    for (int t = 1; t <= 3; t++) tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1110, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL mask_mid_lit got=%b exp=%b", obs, exp_v);
    end
    mask = 4'b1110;
    for (int t = 4; t <= 10; t++) begin
      tick();
      es  = (t >= 8) ? 2'd1 : 2'd0;
      lit = (t >= 10);
      exp_v = {lit ? 4'b1101 : 4'b1111, es, !lit, 1'b0};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mask_mid_slot t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  // Enable drop during digit 1's lit phase, re-enable after 5 cycles.
  task automatic test_enable_drop();
    logic [7:0] obs, exp_v;
    logic [1:0] es;
    logic [3:0] ea;
    int ph;
    mask = 4'b1111;
    do_reset();
    for (int t = 1; t <= 12; t++) tick();
    obs   = {anode_n, sel, blank, frame_done};
    exp_v = {4'b1101, 2'd1, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL en_pre_drop got=%b exp=%b", obs, exp_v);
    end
    enable = 1'b0;
    for (int t = 13; t <= 17; t++) begin
      tick();
      exp_v = {4'b1111, 2'd1, 1'b1, 1'b0};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL en_low t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
    enable = 1'b1;
    for (int t = 18; t <= 25; t++) begin
      tick();
      ph = t - 18;
      es = (t == 25) ? 2'd2 : 2'd1;
      ea = (ph >= 1 && ph <= 6) ? 4'b1101 : 4'b1111;
      exp_v = {ea, es, !(ph >= 1 && ph <= 6), 1'b0};
      obs   = {anode_n, sel, blank, frame_done};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL en_resume t=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    mask   = 4'b1111;
    test_reset();
    test_two_digits();
    test_alternate();
    test_mask_zero();
    test_reset_mid_show();
    test_mask_mid_slot();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
